// File: rtl/move_gen_sequencer_if.sv
// -----------------------------------------------------------------------------
// move_gen_sequencer_if
//   Bundles every non-clock/reset signal of the move-generation sequencer:
//   the search-controller handshake, the square-array control/status lines,
//   the external 64:1 FIFO-output mux, and the move stream to search/eval.
//
//   master : the sequencer (drives unit_reset, rden, sel, move stream, status)
//   slave  : the surrounding system (drives start, unit_done, fifo_empty,
//            fifo_q, move_ready)
//
//   Signals
//     start       controller -> seq   one-cycle pass request
//     unit_reset  seq -> array        array reset pulse
//     unit_done   array -> seq        done flag per square, index {xpos,ypos}
//     fifo_empty  array -> seq        per-square move FIFO empty flag
//     rden        seq -> array        one-hot FIFO read enable
//     sel         seq -> mux          square index for the fifoOut mux
//     fifo_q      mux -> seq          selected FIFO word (bits 159:152 unused)
//     move_out    seq -> search       {flag[6:0], from[5:0], to[5:0]}
//     move_valid  seq -> search       move_out holds a valid move
//     move_ready  search -> seq       consumer accepts move_out
//     busy        seq -> controller   high whenever not idle
//     pass_done   seq -> controller   one-cycle end-of-pass pulse
//     timeout_err seq -> controller   pass aborted waiting for done flags
//     move_count  seq -> controller   valid moves emitted, saturating
// -----------------------------------------------------------------------------
interface move_gen_sequencer_if #(
  parameter int NSQ = 64
);
  logic             start;
  logic             unit_reset;
  logic [NSQ-1:0]   unit_done;
  logic [NSQ-1:0]   fifo_empty;
  logic [NSQ-1:0]   rden;
  logic [5:0]       sel;
  logic [159:0]     fifo_q;
  logic [18:0]      move_out;
  logic             move_valid;
  logic             move_ready;
  logic             busy;
  logic             pass_done;
  logic             timeout_err;
  logic [7:0]       move_count;

  modport master (
    input  start,
    output unit_reset,
    input  unit_done,
    input  fifo_empty,
    output rden,
    output sel,
    input  fifo_q,
    output move_out,
    output move_valid,
    input  move_ready,
    output busy,
    output pass_done,
    output timeout_err,
    output move_count
  );

  modport slave (
    output start,
    input  unit_reset,
    output unit_done,
    output fifo_empty,
    input  rden,
    input  sel,
    output fifo_q,
    input  move_out,
    input  move_valid,
    output move_ready,
    input  busy,
    input  pass_done,
    input  timeout_err,
    input  move_count
  );
endinterface

// File: rtl/move_gen_sequencer.sv
// -----------------------------------------------------------------------------
// move_gen_sequencer
//   Runs one move-generation pass over the 8x8 array of square units:
//     1. pulses unit_reset for one cycle,
//     2. waits (bounded by TIMEOUT) until every unit reports done,
//     3. walks the squares in ascending order, draining each move FIFO word by
//        word through the external fifoOut mux,
//     4. splits every 160-bit word into eight 19-bit slots, drops the slots
//        flagged invalid (bit 18) and streams the rest with a valid/ready
//        handshake, counting them.
//
//   Ports
//     clk    clock
//     reset  asynchronous, active-high reset
//     bus    move_gen_sequencer_if.master (see interface header for signals)
//
//   Every output is taken straight from a flop. The output flops are loaded
//   from the *next* state, so each registered output lines up with the state
//   the FSM is actually in during that cycle.
// -----------------------------------------------------------------------------
module move_gen_sequencer #(
  parameter int NSQ     = 64,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  move_gen_sequencer_if.master bus
);

  localparam int IDX_W  = 6;
  localparam int SLOT_W = 19;
  localparam int NSLOT  = 8;
  localparam int WORD_W = SLOT_W * NSLOT;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NSQ - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT - 1);
  localparam logic [NSQ-1:0]    ONE_HOT0  = {{(NSQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARST,
    S_WAIT,
    S_SCAN,
    S_READ,
    S_LAT,
    S_UNPK,
    S_FIN
  } state_t;

  // ---------------------------------------------------------------------------
  // State, counters and datapath registers
  // ---------------------------------------------------------------------------
  state_t              state_q,       state_d;
  logic [WAIT_W-1:0]   wait_cnt_q,    wait_cnt_d;
  logic [LAT_W-1:0]    lat_cnt_q,     lat_cnt_d;
  logic [IDX_W-1:0]    idx_q,         idx_d;
  logic [2:0]          slot_q,        slot_d;
  // Remaining slots of the word being unpacked; slot currently offered sits
  // in bits [18:0] and the register shifts down one slot per advance.
  logic [WORD_W-1:0]   word_q,        word_d;
  logic [7:0]          move_count_q,  move_count_d;
  logic                timeout_err_q, timeout_err_d;

  // Registered outputs
  logic                unit_reset_q,  unit_reset_d;
  logic [NSQ-1:0]      rden_q,        rden_d;
  logic                busy_q,        busy_d;
  logic                pass_done_q,   pass_done_d;
  logic                move_valid_q,  move_valid_d;

  logic                slot_advance;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case statement so that
    // no path leaves it unassigned; otherwise synthesis infers latches.
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    idx_d         = idx_q;
    slot_d        = slot_q;
    word_d        = word_q;
    move_count_d  = move_count_q;
    timeout_err_d = timeout_err_q;
    slot_advance  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d       = S_ARST;
          move_count_d  = '0;
          timeout_err_d = 1'b0;
          idx_d         = '0;
        end
      end

      S_ARST: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (&bus.unit_done) begin
          idx_d   = '0;
          state_d = S_SCAN;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            timeout_err_d = 1'b1;
            state_d       = S_FIN;
          end
        end
      end

      // One square per cycle; a non-empty square is revisited after each
      // word until its FIFO reports empty.
      S_SCAN: begin
        if (!bus.fifo_empty[idx_q]) begin
          state_d = S_READ;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_FIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_READ: begin
        lat_cnt_d = '0;
        state_d   = S_LAT;
      end

      S_LAT: begin
        if (lat_cnt_q == LAT_LAST) begin
          word_d  = bus.fifo_q[WORD_W-1:0];
          slot_d  = '0;
          state_d = S_UNPK;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end

      // An invalid slot always advances; a valid one waits for move_ready.
      S_UNPK: begin
        slot_advance = !move_valid_q || bus.move_ready;
        if (slot_advance) begin
          if (move_valid_q && (move_count_q != 8'hFF)) begin
            move_count_d = move_count_q + 8'd1;
          end
          word_d = word_q >> SLOT_W;
          if (slot_q == 3'(NSLOT - 1)) begin
            state_d = S_SCAN;
          end else begin
            slot_d = slot_q + 3'd1;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output flops follow the state being entered.
    unit_reset_d = (state_d == S_ARST);
    rden_d       = (state_d == S_READ) ? (ONE_HOT0 << idx_d) : '0;
    busy_d       = (state_d != S_IDLE);
    pass_done_d  = (state_d == S_FIN);
    move_valid_d = (state_d == S_UNPK) && !word_d[SLOT_W-1];
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      lat_cnt_q     <= '0;
      idx_q         <= '0;
      slot_q        <= '0;
      // NOTE: the word register is reset even though it is reloaded before
      // use, because its low slot drives move_out directly and move_out must
      // read zero out of reset.
      word_q        <= '0;
      move_count_q  <= '0;
      timeout_err_q <= 1'b0;
      unit_reset_q  <= 1'b0;
      rden_q        <= '0;
      busy_q        <= 1'b0;
      pass_done_q   <= 1'b0;
      move_valid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, independent of statement order.
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
      idx_q         <= idx_d;
      slot_q        <= slot_d;
      word_q        <= word_d;
      move_count_q  <= move_count_d;
      timeout_err_q <= timeout_err_d;
      unit_reset_q  <= unit_reset_d;
      rden_q        <= rden_d;
      busy_q        <= busy_d;
      pass_done_q   <= pass_done_d;
      move_valid_q  <= move_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.unit_reset  = unit_reset_q;
  assign bus.rden        = rden_q;
  assign bus.sel         = idx_q;
  assign bus.move_out    = word_q[SLOT_W-1:0];
  assign bus.move_valid  = move_valid_q;
  assign bus.busy        = busy_q;
  assign bus.pass_done   = pass_done_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.move_count  = move_count_q;

  // The top byte of the mux output carries no slot data.
  logic unused_fifo_hi;
  assign unused_fifo_hi = ^bus.fifo_q[159:WORD_W];

endmodule

// File: tb/tb_move_gen_sequencer.sv
// -----------------------------------------------------------------------------
// tb_move_gen_sequencer
//   Self-checking bench for move_gen_sequencer. The environment models the
//   square FIFOs as queues of words, the fifoOut mux as a lookup by sel, and
//   the done flags as a programmable delay after unit_reset. Expected moves
//   and read order are derived from the FIFO contents before each pass.
// -----------------------------------------------------------------------------
module tb_move_gen_sequencer;

  localparam int NSQ     = 64;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic reset;

  move_gen_sequencer_if #(.NSQ(NSQ)) bus ();

  move_gen_sequencer #(
    .NSQ    (NSQ),
    .RD_LAT (1),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [159:0] fq [NSQ][$];   // FIFO contents per square
  logic [159:0] dout [NSQ];    // per-square FIFO output register
  logic [18:0]  exp_moves [$];
  int           exp_reads [$];

  logic [159:0] pend_word;
  int           pend_sq;
  bit           pend_valid = 0;
  int           cur_sq     = 0;

  int           done_delay = 1;
  int           done_timer = 0;
  bit           done_armed = 0;
  bit           done_set   = 0;
  logic [63:0]  stuck_mask = '0;

  int           ready_mode = 0;
  int           hold_left  = 0;
  bit           prev_stall = 0;
  logic [18:0]  prev_move  = '0;
  int           accepted   = 0;

  int           busy_cyc   = 0;
  int           pd_cnt     = 0;
  int           ur_cnt     = 0;
  int           stall_cyc  = 0;

  logic         m_rdy;
  int           m_sq;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int sat255(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // Random word; each slot is invalid with probability p_inv percent.
  function automatic logic [159:0] gen_word(input int p_inv);
    logic [159:0] w;
    logic [18:0]  m;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int s = 0; s < 8; s++) begin
      m     = 19'($urandom);
      m[18] = ($urandom_range(99) < p_inv);
      w[19*s +: 19] = m;
    end
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Environment + monitor, all on the falling edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (reset) begin
      bus.move_ready = 1'b0;
      prev_stall     = 0;
      pend_valid     = 0;
      done_armed     = 0;
    end else begin
      // Data for a read issued last cycle becomes visible now.
      if (pend_valid) begin
        dout[pend_sq] = pend_word;
        pend_valid    = 0;
      end

      // Done flags: cleared by the array reset, all set done_delay cycles later.
      if (bus.unit_reset) begin
        ur_cnt++;
        bus.unit_done = '0;
        done_timer    = done_delay;
        done_armed    = 1;
        done_set      = 0;
      end else if (done_armed) begin
        done_timer--;
        if (done_timer <= 0) begin
          bus.unit_done = ~stuck_mask;
          done_armed    = 0;
          done_set      = 1;
        end
      end else if (done_set && stuck_mask == '0 && $urandom_range(3) == 0) begin
        bus.unit_done = {$urandom, $urandom};
      end

      if (bus.busy)      busy_cyc++;
      if (bus.pass_done) pd_cnt++;

      if (bus.rden != '0) begin
        check("rden_onehot", 64'($onehot(bus.rden)), 64'd1);
        if (exp_reads.size() == 0) begin
          check("rden_unexpected", bus.rden, 64'd0);
        end else begin
          m_sq = exp_reads.pop_front();
          check("rden_square", bus.rden, 64'(1) << m_sq);
          check("sel_at_read", 64'(bus.sel), 64'(m_sq));
          cur_sq     = m_sq;
          pend_word  = fq[m_sq].pop_front();
          pend_sq    = m_sq;
          pend_valid = 1;
        end
      end

      if (prev_stall) begin
        check("hold_valid", 64'(bus.move_valid), 64'd1);
        check("hold_move", 64'(bus.move_out), 64'(prev_move));
      end

      if (bus.move_valid) begin
        check("count_live", 64'(bus.move_count), 64'(sat255(accepted)));
        check("sel_hold", 64'(bus.sel), 64'(cur_sq));
      end

      case (ready_mode)
        0: m_rdy = 1'b1;
        1: m_rdy = ($urandom_range(2) != 0);
        2: begin
          if (bus.move_valid && hold_left > 0) begin
            m_rdy = 1'b0;
            hold_left--;
          end else begin
            m_rdy = 1'b1;
          end
        end
        default: m_rdy = 1'b0;
      endcase
      bus.move_ready = m_rdy;

      // Outputs are stable through the next rising edge, so this predicts
      // exactly the transfers that edge will perform.
      if (bus.move_valid && m_rdy) begin
        if (exp_moves.size() == 0) begin
          check("extra_move", 64'(bus.move_valid), 64'd0);
        end else begin
          check("move", 64'(bus.move_out), 64'(exp_moves.pop_front()));
        end
        accepted++;
      end

      prev_stall = bus.move_valid && !m_rdy;
      prev_move  = bus.move_out;
      if (prev_stall) stall_cyc++;
    end

    for (int i = 0; i < NSQ; i++) bus.fifo_empty[i] = (fq[i].size() == 0);
    bus.fifo_q = dout[bus.sel];
  end

  // ---------------------------------------------------------------------------
  // Pass helpers
  // ---------------------------------------------------------------------------
  task automatic clear_fifos();
    for (int i = 0; i < NSQ; i++) fq[i].delete();
  endtask

  // Walk FIFOs in ascending square order, words in order, slots 0..7.
  task automatic build_expect(output int nwords);
    logic [159:0] w;
    logic [18:0]  m;
    exp_moves.delete();
    exp_reads.delete();
    nwords = 0;
    for (int sq = 0; sq < NSQ; sq++) begin
      for (int k = 0; k < fq[sq].size(); k++) begin
        w = fq[sq][k];
        nwords++;
        exp_reads.push_back(sq);
        for (int s = 0; s < 8; s++) begin
          m = w[19*s +: 19];
          if (!m[18]) exp_moves.push_back(m);
        end
      end
    end
  endtask

  task automatic arm_pass(input int d_wait, input logic [63:0] stuck, input int rmode);
    busy_cyc   = 0;
    pd_cnt     = 0;
    ur_cnt     = 0;
    stall_cyc  = 0;
    accepted   = 0;
    hold_left  = 4;
    prev_stall = 0;
    done_delay = d_wait;
    stuck_mask = stuck;
    ready_mode = rmode;
  endtask

  task automatic run_pass(input string name, input int d_wait, input logic [63:0] stuck,
                          input int rmode, input bit poke);
    int nwords, nvalid, exp_busy;
    bit exp_to;
    exp_to = (stuck != '0);
    build_expect(nwords);
    if (exp_to) begin
      exp_moves.delete();
      exp_reads.delete();
    end
    nvalid = exp_moves.size();
    arm_pass(d_wait, stuck, rmode);

    @(negedge clk);
    bus.start = 1'b1;
    repeat (poke ? 8 : 1) @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 6000 && pd_cnt == 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);

    // ARST + WAIT + one SCAN per square + per word (SCAN, READ, LAT, 8 UNPK)
    // + stalled UNPK cycles + FIN.
    exp_busy = exp_to ? (TIMEOUT + 2) : (66 + d_wait + 11 * nwords + stall_cyc);

    check({name, "_pass_done"},   64'(pd_cnt), 64'd1);
    check({name, "_unit_reset"},  64'(ur_cnt), 64'd1);
    check({name, "_move_count"},  64'(bus.move_count), 64'(sat255(nvalid)));
    check({name, "_timeout_err"}, 64'(bus.timeout_err), 64'(exp_to));
    check({name, "_moves_left"},  64'(exp_moves.size()), 64'd0);
    check({name, "_reads_left"},  64'(exp_reads.size()), 64'd0);
    check({name, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_busy));
    check({name, "_idle"},        64'(bus.busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_unit_reset"},  64'(bus.unit_reset), 64'd0);
    check({name, "_rden"},        bus.rden, 64'd0);
    check({name, "_sel"},         64'(bus.sel), 64'd0);
    check({name, "_move_out"},    64'(bus.move_out), 64'd0);
    check({name, "_move_valid"},  64'(bus.move_valid), 64'd0);
    check({name, "_busy"},        64'(bus.busy), 64'd0);
    check({name, "_pass_done"},   64'(bus.pass_done), 64'd0);
    check({name, "_timeout_err"}, 64'(bus.timeout_err), 64'd0);
    check({name, "_move_count"},  64'(bus.move_count), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [159:0] w;
    int           nw;
    bit           seen;

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.unit_done = '0;
    for (int i = 0; i < NSQ; i++) dout[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};
    clear_fifos();

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_release");

    // All FIFOs empty, done 3 cycles after the array reset.
    run_pass("empty", 3, '0, 0, 0);

    // Square 12: slots 0 and 5 valid.
    w = gen_word(100);
    w[18:0]    = {1'b0, 6'h05, 6'o14, 6'o15};
    w[113:95]  = {1'b0, 6'h2A, 6'o14, 6'o24};
    fq[12].push_back(w);
    run_pass("sq12", 2, '0, 0, 0);

    // Same word, first move stalled for 4 cycles.
    fq[12].push_back(w);
    run_pass("sq12_stall", 2, '0, 2, 0);

    // Square 0 holds 2 words, square 63 one word, all slots valid.
    fq[0].push_back(gen_word(0));
    fq[0].push_back(gen_word(0));
    fq[63].push_back(gen_word(0));
    run_pass("sq0_sq63", 1, '0, 0, 0);

    // Done bit 40 stuck low with FIFOs loaded; start held during the pass.
    fq[7].push_back(gen_word(0));
    run_pass("timeout", 1, 64'(1) << 40, 0, 1);
    clear_fifos();
    stuck_mask = '0;

    // More than 255 valid moves: count saturates.
    for (int k = 0; k < 34; k++) fq[5].push_back(gen_word(0));
    run_pass("saturate", 4, '0, 0, 0);

    // Reset while a move is being offered.
    fq[20].push_back(gen_word(0));
    build_expect(nw);
    arm_pass(2, '0, 3);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      seen = bus.move_valid;
    end
    check("midrst_valid_seen", 64'(bus.move_valid), 64'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    clear_fifos();
    exp_moves.delete();
    exp_reads.delete();
    @(negedge clk);
    reset = 1'b0;

    // Randomized passes.
    for (int p = 0; p < 6; p++) begin
      clear_fifos();
      for (int j = 0; j < int'($urandom_range(5, 1)); j++) begin
        m_sq = $urandom_range(NSQ - 1);
        for (int k = 0; k < int'($urandom_range(3, 1)); k++)
          fq[m_sq].push_back(gen_word($urandom_range(100)));
      end
      run_pass($sformatf("rand%0d", p), $urandom_range(8, 1), '0, $urandom_range(1), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/move_gen_sequencer.md
Name: move_gen_sequencer

Overview:
- Controls the 8x8 array of square units for one move-generation pass: pulses the array reset, waits until every unit reports done, then drains each unit's move FIFO in ascending square order.
- Unpacks each 160-bit FIFO word into its eight 19-bit move slots and discards slots flagged invalid.
- Streams valid moves one per handshake to the search/evaluation logic and counts them.
- Sits between the top-level search controller and the square array plus its external 64:1 FIFO-output mux.

Parameters:
- NSQ, 64, number of square units. The index width is fixed at 6 bits.
- RD_LAT, 1, cycles from a FIFO rden pulse until the read data is valid at fifo_q.
- TIMEOUT, 255, maximum number of cycles to wait for all done flags before aborting the pass.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a pass. Ignored unless the block is in IDLE.
- unit_reset  out  1  array reset pulse, drives the reset input of every square unit.
- unit_done  in  64  done flag per square. Bit index = {xpos,ypos}.
- fifo_empty  in  64  FIFO empty flag per square.
- rden  out  64  one-hot FIFO read enable.
- sel  out  6  square index driving the external fifoOut mux.
- fifo_q  in  160  muxed fifoOut. Bits [159:152] are ignored.
- move_out  out  19  move as [7b flag][6b from][6b to]. Flag bit 18 = invalid.
- move_valid  out  1  move_out holds a valid move.
- move_ready  in  1  consumer accepts move_out.
- busy  out  1  high in every state except IDLE.
- pass_done  out  1  one-cycle pulse at the end of a pass.
- timeout_err  out  1  set when a pass aborts on timeout. Cleared by start.
- move_count  out  8  valid moves emitted this pass. Saturates at 255. Cleared by start.

Behaviour:
- Reset (asynchronous): state=IDLE. unit_reset=0, rden=0, sel=0, move_out=0, move_valid=0, busy=0, pass_done=0, timeout_err=0, move_count=0. Internal counters are cleared. Reset takes effect mid-pass with no further FIFO reads or emitted moves.
- All outputs are registered.
- States and transitions:
  - IDLE: on start, go to ARST. Clear move_count and timeout_err.
  - ARST: unit_reset=1 for exactly 1 cycle. Clear the wait counter. Go to WAIT.
  - WAIT: if &unit_done is true, go to SCAN with idx=0. Otherwise increment the wait counter. When the counter reaches TIMEOUT, set timeout_err=1 and go to FIN (no draining).
  - SCAN: sel=idx. If fifo_empty[idx] is clear, go to READ. If it is set and idx==NSQ-1, go to FIN. Otherwise idx++ (one square per cycle).
  - READ: rden[idx]=1 for 1 cycle. Go to LAT.
  - LAT: wait RD_LAT cycles. Latch fifo_q[151:0] into the word register. Set slot=0. Go to UNPK.
  - UNPK: slot s occupies bits [19s+18:19s]; slot 0 is emitted first.
    - Invalid slot (bit 18 set): skip in 1 cycle with move_valid=0.
    - Valid slot: move_valid=1 and move_out=slot. move_out is held stable until move_ready=1. On acceptance, increment move_count (saturating).
    - After slot 7 is skipped or accepted, return to SCAN with the same idx so the rest of that FIFO is drained.
    - Back-to-back valid slots with move_ready held high give one move per cycle.
  - FIN: pass_done=1 for 1 cycle. Go to IDLE.
- sel holds idx from SCAN through UNPK. rden is never active outside READ and is never multi-hot.
- fifo_empty is re-sampled only in SCAN, which is at least RD_LAT+1 cycles after the rden pulse.
- A start that arrives in any state other than IDLE has no effect, including start held high.
- A word that is entirely invalid produces no move_valid and costs 8 UNPK cycles.
- unit_done deasserting during SCAN/UNPK is ignored.

Test Plan:
- Reset mid-UNPK with move_valid=1 -> next edge: move_valid=0, busy=0, rden=0; a later start runs a full pass normally.
- start; unit_done=all-ones 3 cycles after unit_reset; all FIFOs empty -> unit_reset high exactly 1 cycle, 64 SCAN cycles, pass_done pulse, move_count=0, timeout_err=0.
- Only square 12 non-empty, one word with slots 0 and 5 valid (from=6'o14, to=6'o15 and 6'o24), move_ready=1 -> rden[12] pulsed once, sel=12, exactly two moves emitted in slot order, move_count=2.
- Same stimulus with move_ready low for 4 cycles on the first move -> move_out stable for 4 cycles and move_valid held; the count increments only on acceptance.
- Square 0 FIFO holds 2 words, square 63 holds 1 word, all 24 slots valid -> three rden pulses in order (0, 0, 63), move_count=24, pass_done after square 63.
- unit_done bit 40 stuck low -> timeout_err=1 after TIMEOUT cycles in WAIT, no rden activity, pass_done pulses; start during the pass is ignored.
